// File: rtl/fir_cfg_master_if.sv
// AXI-Lite bus between the fir configuration master and the fir slave port.
// There is no B channel: a write is done once both AW and W have handshaken.
interface fir_cfg_master_if #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32
);
  logic                   awvalid;
  logic                   awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid;
  logic                   arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid;
  logic                   rready;
  logic [pDATA_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );
endinterface

// File: rtl/fir_cfg_master.sv
// AXI-Lite initiator that loads the fir tap coefficients, optionally reads
// each one back, programs data_length, starts the engine and polls ap_done.
// Only one bus transaction is ever outstanding.
module fir_cfg_master #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = 11,
  parameter int unsigned VERIFY_TAPS = 1,
  parameter int unsigned POLL_GAP    = 4,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic                    axis_clk,
  input  logic                    axis_rst,
  input  logic                    cfg_start,
  input  logic [31:0]             cfg_data_length,
  input  logic [Tape_Num*32-1:0]  cfg_taps,
  output logic                    cfg_busy,
  output logic                    cfg_done,
  output logic                    cfg_err_mismatch,
  output logic                    cfg_err_timeout,
  fir_cfg_master_if.master        axil
);

  localparam int unsigned       IDX_W    = (Tape_Num > 1) ? $clog2(Tape_Num) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(Tape_Num - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_TAP, S_RD_TAP, S_WR_LEN, S_WR_START, S_GAP, S_POLL, S_FIN
  } state_t;

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_phase_t;

  state_t                  r_state;
  rd_phase_t               r_rd_phase;
  logic                    r_wr_act;
  logic [IDX_W-1:0]        r_idx;
  logic [Tape_Num*32-1:0]  r_taps;
  logic [31:0]             r_len;
  logic [31:0]             r_gap_cnt;
  logic [31:0]             r_poll_cnt;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err_mm;
  logic                    r_err_to;
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic                    r_arvalid;
  logic                    r_rready;
  logic [pADDR_WIDTH-1:0]  r_awaddr;
  logic [pADDR_WIDTH-1:0]  r_araddr;
  logic [pDATA_WIDTH-1:0]  r_wdata;

  logic [31:0]             w_cur_tap;
  logic [31:0]             w_poll_next;
  logic [pADDR_WIDTH-1:0]  w_tap_addr;
  logic [pADDR_WIDTH-1:0]  w_wr_addr;
  logic [pADDR_WIDTH-1:0]  w_rd_addr;
  logic [pDATA_WIDTH-1:0]  w_wr_data;
  logic                    w_wr_fin;
  logic                    w_tap_last;

  assign w_cur_tap   = r_taps[32'(r_idx)*32 +: 32];
  assign w_tap_addr  = pADDR_WIDTH'(32'h20 + 32'(r_idx) * 32'd4);
  assign w_tap_last  = (r_idx == LAST_IDX);
  assign w_poll_next = (r_poll_cnt == '1) ? r_poll_cnt : r_poll_cnt + 32'd1;
  // A channel whose valid is already low has finished its own handshake.
  assign w_wr_fin    = r_wr_act && (!r_awvalid || axil.awready) && (!r_wvalid || axil.wready);

  // Address/data for the transaction the current state issues.
  always_comb begin
    w_wr_addr = '0;
    w_wr_data = '0;
    w_rd_addr = '0;
    case (r_state)
      S_WR_TAP: begin
        w_wr_addr = w_tap_addr;
        w_wr_data = pDATA_WIDTH'(w_cur_tap);
      end
      S_RD_TAP:   w_rd_addr = w_tap_addr;
      S_WR_LEN: begin
        w_wr_addr = pADDR_WIDTH'(32'h10);
        w_wr_data = pDATA_WIDTH'(r_len);
      end
      S_WR_START: w_wr_data = pDATA_WIDTH'(32'h1);
      default: ;
    endcase
  end

  // Sequencer plus the AXI-Lite write/read engines, all registered.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_state    <= S_IDLE;
      r_rd_phase <= RD_IDLE;
      r_wr_act   <= 1'b0;
      r_idx      <= '0;
      r_taps     <= '0;
      r_len      <= '0;
      r_gap_cnt  <= '0;
      r_poll_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err_mm   <= 1'b0;
      r_err_to   <= 1'b0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_awaddr   <= '0;
      r_araddr   <= '0;
      r_wdata    <= '0;
    end else begin
      r_done <= 1'b0;
      // AW and W complete independently; each valid drops on its own ready.
      if (r_awvalid && axil.awready) r_awvalid <= 1'b0;
      if (r_wvalid && axil.wready)   r_wvalid  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_taps     <= cfg_taps;
            r_len      <= cfg_data_length;
            r_idx      <= '0;
            r_err_mm   <= 1'b0;
            r_err_to   <= 1'b0;
            r_poll_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_WR_TAP;
          end
        end

        S_WR_TAP, S_WR_LEN, S_WR_START: begin
          if (!r_wr_act) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_awaddr  <= w_wr_addr;
            r_wdata   <= w_wr_data;
            r_wr_act  <= 1'b1;
          end else if (w_wr_fin) begin
            r_wr_act <= 1'b0;
            r_awaddr <= '0;
            r_wdata  <= '0;
            case (r_state)
              S_WR_TAP: begin
                if (VERIFY_TAPS != 0) begin
                  r_state <= S_RD_TAP;
                end else if (w_tap_last) begin
                  r_idx   <= '0;
                  r_state <= S_WR_LEN;
                end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= S_WR_TAP;
                end
              end
              S_WR_LEN: r_state <= S_WR_START;
              default: begin
                r_gap_cnt <= '0;
                r_state   <= S_GAP;
              end
            endcase
          end
        end

        S_RD_TAP, S_POLL: begin
          case (r_rd_phase)
            RD_IDLE: begin
              r_arvalid  <= 1'b1;
              r_araddr   <= w_rd_addr;
              r_rd_phase <= RD_ADDR;
            end
            RD_ADDR: begin
              if (axil.arready) begin
                r_arvalid  <= 1'b0;
                r_araddr   <= '0;
                r_rready   <= 1'b1;
                r_rd_phase <= RD_DATA;
              end
            end
            default: begin
              if (axil.rvalid) begin
                r_rready   <= 1'b0;
                r_rd_phase <= RD_IDLE;
                if (r_state == S_RD_TAP) begin
                  if (axil.rdata != pDATA_WIDTH'(w_cur_tap)) r_err_mm <= 1'b1;
                  if (w_tap_last) begin
                    r_idx   <= '0;
                    r_state <= S_WR_LEN;
                  end else begin
                    r_idx   <= r_idx + 1'b1;
                    r_state <= S_WR_TAP;
                  end
                end else begin
                  r_poll_cnt <= w_poll_next;
                  if (axil.rdata[1]) begin
                    r_state <= S_FIN;
                  end else if (w_poll_next >= 32'(TIMEOUT)) begin
                    r_err_to <= 1'b1;
                    r_state  <= S_FIN;
                  end else begin
                    r_gap_cnt <= '0;
                    r_state   <= S_GAP;
                  end
                end
              end
            end
          endcase
        end

        S_GAP: begin
          if (r_gap_cnt >= 32'(POLL_GAP)) r_state <= S_POLL;
          else                            r_gap_cnt <= r_gap_cnt + 32'd1;
        end

        default: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cfg_busy         = r_busy;
  assign cfg_done         = r_done;
  assign cfg_err_mismatch = r_err_mm;
  assign cfg_err_timeout  = r_err_to;
  assign axil.awvalid     = r_awvalid;
  assign axil.awaddr      = r_awaddr;
  assign axil.wvalid      = r_wvalid;
  assign axil.wdata       = r_wdata;
  assign axil.arvalid     = r_arvalid;
  assign axil.araddr      = r_araddr;
  assign axil.rready      = r_rready;

endmodule

// File: tb/tb_fir_cfg_master.sv
// Directed bench for fir_cfg_master: behavioural AXI-Lite slave with
// configurable ready skew, tap corruption and status responses, plus a
// transaction log compared against hand-built expected traces.
module tb_fir_cfg_master;
  localparam int TN  = 11;
  localparam int TMO = 8;

  typedef struct packed {
    logic        rd;
    logic [11:0] addr;
    logic [31:0] data;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_start = 1'b0;
  logic [31:0]       cfg_len = '0;
  logic [TN*32-1:0]  cfg_taps = '0;
  logic              busy, done, err_mm, err_to;

  always #5 clk = ~clk;

  fir_cfg_master_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) bus ();

  fir_cfg_master #(
    .pADDR_WIDTH (12),
    .pDATA_WIDTH (32),
    .Tape_Num    (TN),
    .VERIFY_TAPS (1),
    .POLL_GAP    (2),
    .TIMEOUT     (TMO)
  ) dut (
    .axis_clk         (clk),
    .axis_rst         (rst),
    .cfg_start        (cfg_start),
    .cfg_data_length  (cfg_len),
    .cfg_taps         (cfg_taps),
    .cfg_busy         (busy),
    .cfg_done         (done),
    .cfg_err_mismatch (err_mm),
    .cfg_err_timeout  (err_to),
    .axil             (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_taps [TN];

  // slave configuration and monitors
  int   aw_dly = 0, w_dly = 0, corrupt_idx = -1, ready_after = 2, poll_n = 0;
  int   aw_unstable = 0, w_unstable = 0, w_after_hs = 0, overlap = 0, idle_nonzero = 0;
  ev_t  log_q [$];
  logic [31:0] mem [0:1023];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // AXI-Lite slave: decides readys on the falling edge, logs completed transfers
  initial begin
    int          wr_age;
    bit          aw_done, w_done, rd_pend, prev_aw, prev_w;
    logic [11:0] cur_aw, cur_ar, prev_awaddr;
    logic [31:0] cur_w, prev_wdata;
    int          tidx;
    wr_age = 0; aw_done = 0; w_done = 0; rd_pend = 0; prev_aw = 0; prev_w = 0;
    cur_aw = '0; cur_ar = '0; cur_w = '0; prev_awaddr = '0; prev_wdata = '0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
    bus.rvalid = 1'b0; bus.rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wr_age = 0; aw_done = 0; w_done = 0; rd_pend = 0; prev_aw = 0; prev_w = 0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
        bus.rvalid = 1'b0; bus.rdata = '0;
      end else begin
        if (bus.awvalid && prev_aw && bus.awaddr != prev_awaddr) aw_unstable++;
        if (bus.wvalid && prev_w && bus.wdata != prev_wdata) w_unstable++;
        if (bus.wvalid && w_done) w_after_hs++;
        if ((bus.awvalid || bus.wvalid) && (bus.arvalid || bus.rready)) overlap++;
        if (!bus.awvalid && !bus.wvalid && (bus.awaddr != 0 || bus.wdata != 0)) idle_nonzero++;
        prev_aw = bus.awvalid; prev_awaddr = bus.awaddr;
        prev_w  = bus.wvalid;  prev_wdata  = bus.wdata;

        if (bus.awvalid || bus.wvalid) wr_age++; else wr_age = 0;
        bus.awready = bus.awvalid && (wr_age > aw_dly);
        bus.wready  = bus.wvalid  && (wr_age > w_dly);
        if (bus.awvalid && bus.awready) begin aw_done = 1; cur_aw = bus.awaddr; end
        if (bus.wvalid && bus.wready)   begin w_done = 1;  cur_w  = bus.wdata;  end
        if (aw_done && w_done) begin
          log_q.push_back('{rd: 1'b0, addr: cur_aw, data: cur_w});
          mem[cur_aw[11:2]] = cur_w;
          aw_done = 0; w_done = 0;
        end

        bus.arready = bus.arvalid;
        if (bus.arvalid) begin
          log_q.push_back('{rd: 1'b1, addr: bus.araddr, data: 32'h0});
          cur_ar = bus.araddr; rd_pend = 1;
          bus.rvalid = 1'b0; bus.rdata = '0;
        end else if (rd_pend && bus.rready) begin
          bus.rvalid = 1'b1;
          if (cur_ar == 12'h000) begin
            bus.rdata = (poll_n < ready_after) ? 32'h0 : 32'h6;
            poll_n++;
          end else begin
            tidx = (int'(cur_ar) - 32) / 4;
            bus.rdata = mem[cur_ar[11:2]] ^ ((tidx == corrupt_idx) ? 32'h1 : 32'h0);
          end
          rd_pend = 0;
        end else begin
          bus.rvalid = 1'b0; bus.rdata = '0;
        end
      end
    end
  end

  task automatic load_cfg();
    for (int i = 0; i < TN; i++) cfg_taps[i*32 +: 32] = exp_taps[i];
    cfg_len = 32'd600;
  endtask

  task automatic prep(input int awd, input int wd, input int cidx, input int rdy_after);
    aw_dly = awd; w_dly = wd; corrupt_idx = cidx; ready_after = rdy_after; poll_n = 0;
    aw_unstable = 0; w_unstable = 0; w_after_hs = 0; overlap = 0; idle_nonzero = 0;
    log_q.delete();
  endtask

  task automatic start_seq(input string tag);
    @(negedge clk); cfg_start = 1'b1;
    @(negedge clk); cfg_start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    check({tag, "_done"}, 64'(seen), 64'd1);
    if (seen) begin
      check({tag, "_busy_low"}, 64'(busy), 64'd0);
      @(negedge clk);
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
    end
  endtask

  task automatic check_trace(input string tag, input int n_polls);
    ev_t exp_q [$];
    int  n;
    for (int i = 0; i < TN; i++) begin
      exp_q.push_back('{rd: 1'b0, addr: 12'(32'h20 + 4*i), data: exp_taps[i]});
      exp_q.push_back('{rd: 1'b1, addr: 12'(32'h20 + 4*i), data: 32'h0});
    end
    exp_q.push_back('{rd: 1'b0, addr: 12'h010, data: 32'd600});
    exp_q.push_back('{rd: 1'b0, addr: 12'h000, data: 32'h1});
    for (int i = 0; i < n_polls; i++) exp_q.push_back('{rd: 1'b1, addr: 12'h000, data: 32'h0});
    check({tag, "_n_events"}, 64'(log_q.size()), 64'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_ev%0d", tag, i), 64'(log_q[i]), 64'(exp_q[i]));
  endtask

  task automatic check_proto(input string tag);
    check({tag, "_aw_stable"},   64'(aw_unstable),  64'd0);
    check({tag, "_w_stable"},    64'(w_unstable),   64'd0);
    check({tag, "_w_drop"},      64'(w_after_hs),   64'd0);
    check({tag, "_no_overlap"},  64'(overlap),      64'd0);
    check({tag, "_idle_zero"},   64'(idle_nonzero), 64'd0);
  endtask

  function automatic logic [63:0] outs_vec();
    return 64'({bus.awvalid, bus.wvalid, bus.arvalid, bus.rready, bus.awaddr,
                bus.araddr, busy, done, err_mm, err_to}) | 64'(bus.wdata);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    exp_taps = '{32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
                 32'h7FFF_FFFF, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_00FF,
                 32'hFFFF_FF00, 32'h5555_AAAA, 32'h0BAD_F00D};
    load_cfg();
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_vec(), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_quiet", outs_vec(), 64'd0);

    // 1: immediate readys, status 0,0,6
    prep(0, 0, -1, 2);
    start_seq("s1");
    wait_done("s1", 1000);
    check_trace("s1", 3);
    check("s1_err_mm", 64'(err_mm), 64'd0);
    check("s1_err_to", 64'(err_to), 64'd0);
    check_proto("s1");

    // 2: wready three cycles ahead of awready
    prep(3, 0, -1, 2);
    start_seq("s2");
    wait_done("s2", 1500);
    check_trace("s2", 3);
    check_proto("s2");

    // 3: tap 5 readback corrupted
    prep(0, 0, 5, 2);
    start_seq("s3");
    wait_done("s3", 1000);
    check_trace("s3", 3);
    check("s3_err_mm", 64'(err_mm), 64'd1);
    check("s3_err_to", 64'(err_to), 64'd0);

    // 4: status never done -> TMO polls then timeout; mismatch flag cleared on start
    prep(0, 0, -1, 1000);
    start_seq("s4");
    wait_done("s4", 1500);
    check_trace("s4", TMO);
    check("s4_err_to", 64'(err_to), 64'd1);
    check("s4_err_mm", 64'(err_mm), 64'd0);

    // 5: reset during the fourth tap write, then a clean rerun
    prep(0, 0, -1, 2);
    start_seq("s5");
    found = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (bus.awvalid && bus.awaddr == 12'h02C) begin found = 1; break; end
    end
    check("s5_tap3_seen", 64'(found), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("s5_reset_outputs", outs_vec(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("s5_quiet_after_reset", outs_vec(), 64'd0);
    prep(0, 0, -1, 2);
    start_seq("s5r");
    wait_done("s5r", 1000);
    check_trace("s5r", 3);
    check_proto("s5r");

    // 6: second cfg_start while busy with different inputs is ignored
    prep(0, 0, -1, 2);
    start_seq("s6");
    repeat (10) @(negedge clk);
    for (int i = 0; i < TN; i++) cfg_taps[i*32 +: 32] = 32'hCAFE_F00D;
    cfg_len = 32'd1234;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    wait_done("s6", 1000);
    check_trace("s6", 3);
    check("s6_err_mm", 64'(err_mm), 64'd0);
    repeat (5) @(negedge clk);
    check("s6_no_restart", 64'(busy), 64'd0);
    load_cfg();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
